updown_mod_counter: RTL

Parametrised successor to the 4-bit enable-only up counter. Counts up or down modulo MODULUS, with these added features:
- synchronous parallel load
- selectable wrap or saturate behaviour at the range ends
- a combinational terminal-count output for cascading counters (e.g. BCD digit chains)
- a sticky overflow flag

Used as the general counter primitive in later timer, BCD-display and clock-divider labs.

---
 rtl/updown_mod_counter_pkg.sv | 19 +
 rtl/updown_mod_counter_next.sv | 64 ++++++
 rtl/updown_mod_counter.sv | 75 +++++++
 3 files changed

// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_pkg
// Brief    : Shared mode constants for the up/down modulo counter family
//            (the counter_defs constant set).
// Revision : 1.0 - initial release
// ============================================================================
package updown_mod_counter_pkg;

    // End-of-range behaviour selected by Sat
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Count direction selected by Up
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage : updown_mod_counter_pkg
`default_nettype wire

// File: rtl/updown_mod_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter_next
// Brief    : Combinational next-count and terminal-count logic for the
//            up/down modulo counter (the counter_next stage).
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter_next
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] Count,
    input  logic             En,
    input  logic             Up,
    input  logic             Sat,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] NextCount,
    output logic             Tc
);

    // Top of range kept one bit wider so MODULUS = 2**WIDTH compares correctly
    localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_max     = c_max_ext[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_zero    = '0;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic w_at_max;
    logic w_at_min;
    logic w_load_over;

    assign w_at_max    = ({1'b0, Count} == c_max_ext);
    assign w_at_min    = (Count == c_zero);
    assign w_load_over = ({1'b0, LoadVal} > c_max_ext);

    // Carry-out to the next stage; suppressed while a load is in progress
    assign Tc = En & ~Load & ((Up & w_at_max) | (~Up & w_at_min));

    // Next count: load (clamped) beats counting; idle holds
    always_comb begin
        NextCount = Count;
        if (Load) begin
            NextCount = w_load_over ? c_max : LoadVal;
        end else if (En) begin
            if (Up == DIR_UP) begin
                if (w_at_max) begin
                    NextCount = (Sat == CNT_SAT) ? c_max : c_zero;
                end else begin
                    NextCount = Count + c_one;
                end
            end else begin
                if (w_at_min) begin
                    NextCount = (Sat == CNT_SAT) ? c_zero : c_max;
                end else begin
                    NextCount = Count - c_one;
                end
            end
        end
    end

endmodule : updown_mod_counter_next
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Brief    : Parametrised up/down modulo counter with parallel load,
//            wrap/saturate mode, cascadable terminal count and sticky
//            overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Up,
    input  logic             Sat,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] c_rst_val = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_count;
    logic             w_tc;

    updown_mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .Count     (r_count),
        .En        (En),
        .Up        (Up),
        .Sat       (Sat),
        .Load      (Load),
        .LoadVal   (LoadVal),
        .NextCount (w_next_count),
        .Tc        (w_tc)
    );

    // Count register; reset overrides load and enable
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= c_rst_val;
        end else begin
            r_count <= w_next_count;
        end
    end

    // Sticky overflow: a boundary event wins over a same-cycle clear
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ovf <= 1'b0;
        end else if (w_tc) begin
            r_ovf <= 1'b1;
        end else if (ClrOvf) begin
            r_ovf <= 1'b0;
        end
    end

    assign Count = r_count;
    assign Tc    = w_tc;
    assign Ovf   = r_ovf;

endmodule : updown_mod_counter
`default_nettype wire
